// File: rtl/m68k_mmu_pkg.sv
// Shared encodings for the 68000 page translator: function codes, fixed
// physical kernel windows and supervisor region selectors.
package m68k_mmu_pkg;

    localparam logic [2:0] FC_USER_DATA  = 3'b001;
    localparam logic [2:0] FC_USER_PROG  = 3'b010;
    localparam logic [2:0] FC_SUPER_DATA = 3'b101;
    localparam logic [2:0] FC_SUPER_PROG = 3'b110;
    localparam logic [2:0] FC_CPU_SPACE  = 3'b111;

    localparam logic [15:0] KERNEL_RAM_BASE = 16'h8000;
    localparam logic [15:0] KERNEL_ROM_BASE = 16'h4000;

    localparam logic [1:0] REGION_KERNEL_RAM = 2'b00;
    localparam logic [1:0] REGION_KERNEL_ROM = 2'b01;
    localparam logic [1:0] REGION_WINDOW_1   = 2'b10;
    localparam logic [1:0] REGION_WINDOW_2   = 2'b11;

    // Any code with fc[2] clear is a user-space access.
    function automatic logic is_user_fc(input logic [2:0] fc);
        return ~fc[2];
    endfunction

endpackage

// File: rtl/m68k_mmu_super_map.sv
// Supervisor-mode page decode: two fixed kernel windows and two windows whose
// physical page group comes from the supervisor map registers.
module mmu_super_map
    import m68k_mmu_pkg::*;
(
    input  logic [11:0] addr_in,
    input  logic [7:0]  supervisor_map_1,
    input  logic [7:0]  supervisor_map_2,
    output logic [15:0] page
);

    // The register windows drop addr_in[9:8], so each aliases every 1 MiB.
    always_comb begin
        page = '0;
        case (addr_in[11:10])
            REGION_KERNEL_RAM: page = KERNEL_RAM_BASE | {6'b0, addr_in[9:0]};
            REGION_KERNEL_ROM: page = KERNEL_ROM_BASE | {6'b0, addr_in[9:0]};
            REGION_WINDOW_1:   page = {supervisor_map_1, addr_in[7:0]};
            REGION_WINDOW_2:   page = {supervisor_map_2, addr_in[7:0]};
            default:           page = '0;
        endcase
    end

endmodule

// File: rtl/m68k_mmu.sv
// 68000 logical-to-physical page translator. Fully combinational; reset_n
// gates the output asynchronously and clk is present only for the bus port.
module m68k_mmu
    import m68k_mmu_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        enable,
    input  logic [11:0] addr_in,
    input  logic [2:0]  fc,
    input  logic [3:0]  user_map,
    input  logic [7:0]  supervisor_map_1,
    input  logic [7:0]  supervisor_map_2,
    output logic [15:0] table_ram_addr_bus,
    input  logic [15:0] table_ram_data_bus,
    output logic [15:0] addr_out
);

    logic [15:0] super_page;
    logic        unused_clk;

    assign unused_clk = clk;

    mmu_super_map u_super_map (
        .addr_in          (addr_in),
        .supervisor_map_1 (supervisor_map_1),
        .supervisor_map_2 (supervisor_map_2),
        .page             (super_page)
    );

    // Driven regardless of enable so the table RAM can start its access early.
    assign table_ram_addr_bus = {user_map, addr_in};

    always_comb begin
        addr_out = '0;
        if (reset_n && enable) begin
            if (is_user_fc(fc))
                addr_out = table_ram_data_bus;
            else if (fc != FC_CPU_SPACE)
                addr_out = super_page;
        end
    end

endmodule

// File: tb/tb_m68k_mmu.sv
// Scoreboarded bench for m68k_mmu: expected pages are queued as stimulus is
// applied and popped when the combinational output is sampled.
module tb_m68k_mmu;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        enable;
    logic [11:0] addr_in;
    logic [2:0]  fc;
    logic [3:0]  user_map;
    logic [7:0]  supervisor_map_1;
    logic [7:0]  supervisor_map_2;
    logic [15:0] table_ram_addr_bus;
    logic [15:0] table_ram_data_bus;
    logic [15:0] addr_out;

    int tests = 0;
    int fails = 0;
    logic [15:0] exp_q[$];

    always #5 clk = ~clk;

    m68k_mmu dut (
        .clk                (clk),
        .reset_n            (reset_n),
        .enable             (enable),
        .addr_in            (addr_in),
        .fc                 (fc),
        .user_map           (user_map),
        .supervisor_map_1   (supervisor_map_1),
        .supervisor_map_2   (supervisor_map_2),
        .table_ram_addr_bus (table_ram_addr_bus),
        .table_ram_data_bus (table_ram_data_bus),
        .addr_out           (addr_out)
    );

    task automatic apply(input logic en, input logic [2:0] f, input logic [11:0] a,
                         input logic [3:0] um, input logic [15:0] data);
        @(negedge clk);
        enable = en; fc = f; addr_in = a; user_map = um; table_ram_data_bus = data;
    endtask

    task automatic test_reset();
        logic [15:0] e;
        reset_n = 1'b0; enable = 1'b1; fc = 3'b001; addr_in = 12'h123;
        user_map = 4'h5; table_ram_data_bus = 16'hBEEF;
        supervisor_map_1 = 8'h00; supervisor_map_2 = 8'h00;
        exp_q.push_back(16'h0000);
        @(negedge clk); #1;
        e = exp_q.pop_front(); tests++;
        if (addr_out !== e) begin
            fails++; $display("FAIL reset_out got=%h exp=%h", addr_out, e);
        end
        tests++;
        if (table_ram_addr_bus !== 16'h5123) begin
            fails++; $display("FAIL reset_tbl_addr got=%h exp=%h", table_ram_addr_bus, 16'h5123);
        end
        reset_n = 1'b1;
    endtask

    task automatic test_user_data();
        logic [15:0] e;
        apply(1'b1, 3'b001, 12'h000, 4'h0, 16'h0002);
        exp_q.push_back(16'h0002);
        #1; e = exp_q.pop_front(); tests++;
        if (addr_out !== e) begin
            fails++; $display("FAIL user_data got=%h exp=%h", addr_out, e);
        end
        apply(1'b0, 3'b001, 12'h000, 4'h0, 16'h0002);
        exp_q.push_back(16'h0000);
        #1; e = exp_q.pop_front(); tests++;
        if (addr_out !== e) begin
            fails++; $display("FAIL user_disabled got=%h exp=%h", addr_out, e);
        end
    endtask

    task automatic test_user_lookup();
        logic [11:0] addrs[5] = '{12'd0, 12'd0, 12'd2, 12'd2, 12'd2};
        logic [3:0]  maps[5]  = '{4'd0, 4'd1, 4'd0, 4'd1, 4'd4};
        logic [15:0] tbl[5]   = '{16'h0000, 16'h1000, 16'h0002, 16'h1002, 16'h4002};
        logic [15:0] e;
        for (int i = 0; i < 5; i++) begin
            apply(1'b1, 3'b010, addrs[i], maps[i], 16'h0F00 + 16'(i));
            exp_q.push_back(16'h0F00 + 16'(i));
            #1; tests++;
            if (table_ram_addr_bus !== tbl[i]) begin
                fails++; $display("FAIL user_tbl_addr[%0d] got=%h exp=%h", i, table_ram_addr_bus, tbl[i]);
            end
            e = exp_q.pop_front(); tests++;
            if (addr_out !== e) begin
                fails++; $display("FAIL user_lookup[%0d] got=%h exp=%h", i, addr_out, e);
            end
        end
    endtask

    task automatic test_kernel();
        logic [11:0] addrs[8] = '{12'h000, 12'h001, 12'h3FE, 12'h3FF,
                                  12'h400, 12'h401, 12'h7FE, 12'h7FF};
        logic [15:0] exps[8]  = '{16'h8000, 16'h8001, 16'h83FE, 16'h83FF,
                                  16'h4000, 16'h4001, 16'h43FE, 16'h43FF};
        logic [15:0] e;
        for (int i = 0; i < 8; i++) begin
            apply(1'b1, 3'b101, addrs[i], 4'hF, 16'hFFFF);
            exp_q.push_back(exps[i]);
            #1; e = exp_q.pop_front(); tests++;
            if (addr_out !== e) begin
                fails++; $display("FAIL kernel[%0d] got=%h exp=%h", i, addr_out, e);
            end
        end
    endtask

    task automatic test_windows();
        logic [11:0] addrs[4] = '{12'h812, 12'hF34, 12'h912, 12'hC34};
        logic [15:0] exps[4]  = '{16'hA512, 16'h3C34, 16'hA512, 16'h3C34};
        logic [15:0] e;
        supervisor_map_1 = 8'hA5; supervisor_map_2 = 8'h3C;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, (i % 2 == 0) ? 3'b101 : 3'b110, addrs[i], 4'h0, 16'h1111);
            exp_q.push_back(exps[i]);
            #1; e = exp_q.pop_front(); tests++;
            if (addr_out !== e) begin
                fails++; $display("FAIL window[%0d] got=%h exp=%h", i, addr_out, e);
            end
        end
    endtask

    task automatic test_cpu_space();
        logic [11:0] addrs[4] = '{12'h000, 12'h400, 12'h812, 12'hFFF};
        logic [15:0] e;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 3'b111, addrs[i], 4'h3, 16'h1234);
            exp_q.push_back(16'h0000);
            #1; e = exp_q.pop_front(); tests++;
            if (addr_out !== e) begin
                fails++; $display("FAIL cpu_space[%0d] got=%h exp=%h", i, addr_out, e);
            end
        end
    endtask

    task automatic test_reset_pulse();
        logic [15:0] e;
        apply(1'b1, 3'b001, 12'h055, 4'h2, 16'hC0DE);
        #1; reset_n = 1'b0;
        exp_q.push_back(16'h0000);
        #1; e = exp_q.pop_front(); tests++;
        if (addr_out !== e) begin
            fails++; $display("FAIL reset_assert got=%h exp=%h", addr_out, e);
        end
        tests++;
        if (table_ram_addr_bus !== 16'h2055) begin
            fails++; $display("FAIL reset_tbl_keep got=%h exp=%h", table_ram_addr_bus, 16'h2055);
        end
        reset_n = 1'b1;
        exp_q.push_back(16'hC0DE);
        #1; e = exp_q.pop_front(); tests++;
        if (addr_out !== e) begin
            fails++; $display("FAIL reset_release got=%h exp=%h", addr_out, e);
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] e, data;
        logic [11:0] a;
        logic [2:0]  f;
        logic        en;
        for (int i = 0; i < 40; i++) begin
            en = 1'($urandom_range(0, 3) != 0);
            f = 3'($urandom_range(0, 7));
            a = 12'($urandom);
            data = 16'($urandom);
            supervisor_map_1 = 8'($urandom);
            supervisor_map_2 = 8'($urandom);
            apply(en, f, a, 4'($urandom), data);
            if (!en || f == 3'b111)   e = 16'h0000;
            else if (f[2] == 1'b0)    e = data;
            else if (a[11:10] == 2'd0) e = 16'h8000 + 16'(a[9:0]);
            else if (a[11:10] == 2'd1) e = 16'h4000 + 16'(a[9:0]);
            else if (a[11:10] == 2'd2) e = {supervisor_map_1, a[7:0]};
            else                       e = {supervisor_map_2, a[7:0]};
            exp_q.push_back(e);
            #1; e = exp_q.pop_front(); tests++;
            if (addr_out !== e) begin
                fails++; $display("FAIL random[%0d] fc=%b a=%h got=%h exp=%h", i, f, a, addr_out, e);
            end
        end
    endtask

    initial begin
        test_reset();
        test_user_data();
        test_user_lookup();
        test_kernel();
        test_windows();
        test_cpu_space();
        test_reset_pulse();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
